// File: rtl/arb_2x1_seq_pkg.sv
// Shared types and encodings for the 2:1 arbiter feeding mux_2x1_seq.
// Build option: define ARB_2X1_RR_EN for round-robin; otherwise high branch has fixed priority.
package arb_2x1_seq_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_LOW  = 2'd1,
        GRANT_HIGH = 2'd2
    } arb_state_e;

    // Command encodings understood by the downstream mux
    localparam logic CMD_LOW  = 1'b0;
    localparam logic CMD_HIGH = 1'b1;

endpackage

// File: rtl/arb_2x1_seq_sync_fifo.sv
// Per-branch buffer: registered ready, no empty bypass, pointers wrap at FIFO_DEPTH.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    input  logic                  pop_i,
    output logic                  empty_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  ready_q;
    logic                  do_push_c;
    logic                  do_pop_c;

    // ready_q is only high below full, so a push is never taken at full even with a pop
    assign do_push_c = push_i && ready_q;
    assign do_pop_c  = pop_i && (cnt_q != '0);

    // Occupancy next value
    always_comb begin
        cnt_d = cnt_q;
        case ({do_push_c, do_pop_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers, occupancy and registered ready; reset flushes the buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (do_push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d != CNT_W'(FIFO_DEPTH));
        end
    end

    // Storage array; contents are don't-care while the occupancy is zero
    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_ptr_q] <= data_i;
    end

    assign ready_o = ready_q;
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/arb_2x1_seq.sv
// Two buffered input branches arbitrated onto one registered output word for mux_2x1_seq.
// Build option: ARB_2X1_RR_EN selects round-robin; undefined gives fixed high-branch priority.
module arb_2x1_seq
    import arb_2x1_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned COMMMAND_WIDTH = 1,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_valid_low,
    input  logic [DATA_WIDTH-1:0]       i_data_low,
    output logic                        o_ready_low,
    input  logic                        i_valid_high,
    input  logic [DATA_WIDTH-1:0]       i_data_high,
    output logic                        o_ready_high,
    output logic                        o_valid,
    output logic [2*DATA_WIDTH-1:0]     o_data_bus,
    output logic                        o_en,
    output logic [COMMMAND_WIDTH-1:0]   o_cmd,
    input  logic                        i_ready
);

    logic                      empty_low;
    logic                      empty_high;
    logic [DATA_WIDTH-1:0]     head_low;
    logic [DATA_WIDTH-1:0]     head_high;
    logic                      pop_low_c;
    logic                      pop_high_c;
    logic                      slot_c;
    logic                      any_c;
    logic                      grant_high_c;

    arb_state_e                state_q;
    arb_state_e                state_d;
    logic                      valid_q;
    logic [2*DATA_WIDTH-1:0]   data_q;
    logic [COMMMAND_WIDTH-1:0] cmd_q;
`ifdef ARB_2X1_RR_EN
    logic                      last_high_q;
`endif

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo_low (
        .clk     (clk),
        .rst     (rst),
        .push_i  (i_valid_low),
        .data_i  (i_data_low),
        .ready_o (o_ready_low),
        .pop_i   (pop_low_c),
        .empty_o (empty_low),
        .data_o  (head_low)
    );

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo_high (
        .clk     (clk),
        .rst     (rst),
        .push_i  (i_valid_high),
        .data_i  (i_data_high),
        .ready_o (o_ready_high),
        .pop_i   (pop_high_c),
        .empty_o (empty_high),
        .data_o  (head_high)
    );

    // Load opportunity: output register empty or being drained this cycle
    assign slot_c = (state_q == IDLE) || i_ready;
    assign any_c  = !empty_low || !empty_high;

    // Grant selection and next state; a lone non-empty branch always wins
    always_comb begin
        grant_high_c = !empty_high;
        if (!empty_low && !empty_high) begin
`ifdef ARB_2X1_RR_EN
            grant_high_c = !last_high_q;
`else
            grant_high_c = 1'b1;
`endif
        end
        state_d = state_q;
        if (slot_c) begin
            if (!any_c)            state_d = IDLE;
            else if (grant_high_c) state_d = GRANT_HIGH;
            else                   state_d = GRANT_LOW;
        end
        pop_high_c = slot_c && any_c && grant_high_c;
        pop_low_c  = slot_c && any_c && !grant_high_c;
    end

    // Output state machine and registered output word; held during stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            data_q      <= '0;
            cmd_q       <= COMMMAND_WIDTH'(CMD_LOW);
`ifdef ARB_2X1_RR_EN
            last_high_q <= 1'b1;
`endif
        end else if (slot_c) begin
            state_q <= state_d;
            if (any_c) begin
                valid_q <= 1'b1;
                if (grant_high_c) begin
                    data_q <= {head_high, {DATA_WIDTH{1'b0}}};
                    cmd_q  <= COMMMAND_WIDTH'(CMD_HIGH);
                end else begin
                    data_q <= {{DATA_WIDTH{1'b0}}, head_low};
                    cmd_q  <= COMMMAND_WIDTH'(CMD_LOW);
                end
`ifdef ARB_2X1_RR_EN
                last_high_q <= grant_high_c;
`endif
            end else begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end
        end
    end

    assign o_valid    = valid_q;
    assign o_en       = valid_q;
    assign o_data_bus = data_q;
    assign o_cmd      = cmd_q;

endmodule
